// File: rtl/neuron_sequencer.sv
// Feeds one layer's neurons through the shared 8-input saturating adder: collects
// eight products per neuron, pairs them with the stored bias, applies optional ReLU.
module neuron_sequencer #(
   parameter int NUM_IN      = 8,
   parameter int DATA_W      = 8,
   parameter int MAX_NEURONS = 16,
   parameter int NIDX_W      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [NIDX_W-1:0]        cfg_addr,
   input  logic [DATA_W-1:0]        cfg_bias,
   input  logic                     start,
   input  logic [NIDX_W:0]          num_neurons,
   input  logic                     relu_en,
   output logic                     busy,
   output logic                     done,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   output logic [NUM_IN*DATA_W-1:0] add_vec,
   output logic [DATA_W-1:0]        add_bias,
   input  logic [DATA_W-1:0]        add_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [NIDX_W-1:0]        out_idx
);

   localparam int SLOT_W = $clog2(NUM_IN);
   localparam logic [NIDX_W:0]   MAX_CNT   = (NIDX_W+1)'(MAX_NEURONS);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_IN-1);

   typedef enum logic [1:0] {IDLE, LOAD, EVAL, OUT} state_t;

   state_t                    state_r;
   state_t                    state_s;
   logic [DATA_W-1:0]         bias_r [MAX_NEURONS];
   logic [NIDX_W:0]           count_r;
   logic                      relu_r;
   logic [NIDX_W-1:0]         idx_r;
   logic [SLOT_W-1:0]         slot_cnt_r;
   logic                      in_ready_r;
   logic                      busy_r;
   logic                      done_r;
   logic                      out_valid_r;
   logic [DATA_W-1:0]         out_data_r;
   logic [NIDX_W-1:0]         out_idx_r;
   logic [NUM_IN*DATA_W-1:0]  add_vec_r;
   logic [DATA_W-1:0]         add_bias_r;

   logic                      start_acc_s;
   logic                      beat_s;
   logic                      slot_last_s;
   logic                      last_s;
   logic                      bias_we_s;
   logic [NIDX_W:0]           cnt_s;

   // A start in the done cycle is dropped so back-to-back layers need one idle cycle.
   assign start_acc_s = (state_r == IDLE) && start && (num_neurons != {(NIDX_W+1){1'b0}}) && !done_r;
   assign beat_s      = in_valid && in_ready_r;
   assign slot_last_s = (slot_cnt_r == SLOT_LAST);
   assign last_s      = ({1'b0, idx_r} == (count_r - {{NIDX_W{1'b0}}, 1'b1}));
   assign bias_we_s   = cfg_we && (state_r == IDLE) && !start_acc_s;
   assign cnt_s       = (num_neurons > MAX_CNT) ? MAX_CNT : num_neurons;

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_acc_s) state_s = LOAD;
            else             state_s = IDLE;
         end
         LOAD: begin
            if (beat_s && slot_last_s) state_s = EVAL;
            else                       state_s = LOAD;
         end
         EVAL: state_s = OUT;
         OUT: begin
            if (out_ready) begin
               if (last_s) state_s = IDLE;
               else        state_s = LOAD;
            end else begin
               state_s = OUT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_s;
   end

   // Datapath, handshake outputs and bias file.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r     <= {(NIDX_W+1){1'b0}};
         relu_r      <= 1'b0;
         idx_r       <= {NIDX_W{1'b0}};
         slot_cnt_r  <= {SLOT_W{1'b0}};
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_idx_r   <= {NIDX_W{1'b0}};
         add_vec_r   <= {(NUM_IN*DATA_W){1'b0}};
         add_bias_r  <= {DATA_W{1'b0}};
         for (int i = 0; i < MAX_NEURONS; i++) bias_r[i] <= {DATA_W{1'b0}};
      end else begin
         in_ready_r <= (state_s == LOAD);
         busy_r     <= (state_s != IDLE);
         done_r     <= (state_r == OUT) && out_ready && last_s;
         if (start_acc_s) begin
            count_r    <= cnt_s;
            relu_r     <= relu_en;
            idx_r      <= {NIDX_W{1'b0}};
            slot_cnt_r <= {SLOT_W{1'b0}};
         end else if (beat_s) begin
            add_vec_r[slot_cnt_r*DATA_W +: DATA_W] <= in_data;
            if (slot_last_s) begin
               slot_cnt_r <= {SLOT_W{1'b0}};
               add_bias_r <= bias_r[idx_r];
            end else begin
               slot_cnt_r <= slot_cnt_r + {{(SLOT_W-1){1'b0}}, 1'b1};
            end
         end else if (state_r == EVAL) begin
            out_data_r  <= (relu_r && add_result[DATA_W-1]) ? {DATA_W{1'b0}} : add_result;
            out_idx_r   <= idx_r;
            out_valid_r <= 1'b1;
         end else if ((state_r == OUT) && out_ready) begin
            out_valid_r <= 1'b0;
            if (!last_s) idx_r <= idx_r + {{(NIDX_W-1){1'b0}}, 1'b1};
         end
         if (bias_we_s) bias_r[cfg_addr] <= cfg_bias;
      end
   end

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_idx   = out_idx_r;
   assign add_vec   = add_vec_r;
   assign add_bias  = add_bias_r;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a behavioural saturating-adder environment
// and a result scoreboard derived from plain integer neuron arithmetic.
module tb_neuron_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [7:0]  cfg_bias;
   logic        start;
   logic [4:0]  num_neurons;
   logic        relu_en;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [63:0] add_vec;
   logic [7:0]  add_bias;
   logic [7:0]  add_result;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [3:0]  out_idx;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [7:0]  last_data = 8'h00;
   logic [11:0] exp_q [$];
   logic [7:0]  lb [16];
   logic [7:0]  lp [16][8];

   neuron_sequencer dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias),
      .start(start), .num_neurons(num_neurons), .relu_en(relu_en), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .add_vec(add_vec), .add_bias(add_bias), .add_result(add_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
   );

   always #5 clk = ~clk;

   // The shared adder: signed sum of eight slots plus bias, clamped to int8.
   always_comb begin
      int s;
      s = $signed(add_bias);
      for (int k = 0; k < 8; k++) s = s + $signed(add_vec[8*k +: 8]);
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      add_result = 8'(s);
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endfunction

   function automatic logic [7:0] model(input logic [7:0] b, input logic [7:0] p [8], input bit relu);
      int s;
      s = $signed(b);
      for (int k = 0; k < 8; k++) s = s + $signed(p[k]);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      if (relu && s < 0) s = 0;
      return 8'(s);
   endfunction

   // Per-cycle scoreboard and stall-stability monitor.
   logic       prev_hold = 1'b0;
   logic [7:0] prev_data;
   logic [3:0] prev_idx;
   always @(negedge clk) begin
      logic [11:0] e;
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (out_valid) chk("in_ready_low_while_out_valid", {31'd0, in_ready}, 32'd0);
         if (prev_hold) begin
            chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
            chk("stall_data_held", {24'd0, out_data}, {24'd0, prev_data});
            chk("stall_idx_held", {28'd0, out_idx}, {28'd0, prev_idx});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("result_data", {24'd0, out_data}, {24'd0, e[7:0]});
               chk("result_idx", {28'd0, out_idx}, {28'd0, e[11:8]});
            end
            last_data = out_data;
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_idx  = out_idx;
         if (done) done_cnt++;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
      chk({tag, "_out_idx"}, {28'd0, out_idx}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_add_vec_lo"}, add_vec[31:0], 32'd0);
      chk({tag, "_add_vec_hi"}, add_vec[63:32], 32'd0);
      chk({tag, "_add_bias"}, {24'd0, add_bias}, 32'd0);
   endtask

   task automatic write_bias(input logic [3:0] a, input logic [7:0] b);
      cfg_we = 1'b1; cfg_addr = a; cfg_bias = b;
      tick;
      cfg_we = 1'b0;
   endtask

   task automatic start_layer(input logic [4:0] n, input bit relu, input bit cfgpoke);
      start = 1'b1; num_neurons = n; relu_en = relu;
      if (cfgpoke) begin
         cfg_we = 1'b1; cfg_addr = 4'd0; cfg_bias = 8'h40;
      end
      tick;
      start = 1'b0; cfg_we = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic send_beat(input logic [7:0] d);
      int g;
      in_valid = 1'b1; in_data = d; g = 0;
      while (!in_ready && g < 100) begin
         tick;
         g++;
      end
      if (g >= 100) chk("in_ready_timeout", 32'd1, 32'd0);
      tick;
      in_valid = 1'b0;
   endtask

   task automatic run_layer(input logic [4:0] nreq, input int n, input bit relu, input bit wr,
                            input int stall_n, input bit poke, input bit cfgpoke);
      logic [7:0] p [8];
      int d0;
      if (wr) for (int i = 0; i < n; i++) write_bias(4'(i), lb[i]);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 8; k++) p[k] = lp[i][k];
         exp_q.push_back({4'(i), model(lb[i], p, relu)});
      end
      d0 = done_cnt;
      start_layer(nreq, relu, cfgpoke);
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            if (poke && i == 0 && b == 3) begin
               start = 1'b1; num_neurons = 5'd5;
               cfg_we = 1'b1; cfg_addr = 4'd1; cfg_bias = 8'h55;
               tick;
               start = 1'b0; cfg_we = 1'b0;
            end
            send_beat(lp[i][b]);
         end
         if (i == stall_n) begin
            out_ready = 1'b0;
            tick;
            for (int c = 0; c < 5; c++) begin
               chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
               chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
               tick;
            end
            out_ready = 1'b1;
            if (i == n - 1) begin
               tick;
               chk("done_after_stall", {31'd0, done}, 32'd1);
            end
         end else begin
            chk("eval_no_valid", {31'd0, out_valid}, 32'd0);
            tick;
            chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
            if (i == n - 1) begin
               tick;
               chk("done_pulse", {31'd0, done}, 32'd1);
               chk("busy_fall", {31'd0, busy}, 32'd0);
               start = 1'b1; num_neurons = 5'd1;
               tick;
               start = 1'b0;
               chk("start_in_done_cycle_ignored", {31'd0, busy}, 32'd0);
            end
         end
      end
      tick;
      tick;
      chk("done_count", done_cnt - d0, 32'd1);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
   endtask

   task automatic fill(input int n, input logic [7:0] b0, input logic [7:0] bstep, input logic [7:0] pv);
      for (int i = 0; i < n; i++) begin
         lb[i] = b0 + 8'(i) * bstep;
         for (int k = 0; k < 8; k++) lp[i][k] = pv;
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_bias = 8'd0; start = 1'b0;
      num_neurons = 5'd0; relu_en = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
      tick;
      tick;
      check_reset_outputs("reset");
      rst = 1'b0;
      tick;

      fill(1, 8'h03, 8'h00, 8'h01);
      run_layer(5'd1, 1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      chk("basic_sum", {24'd0, last_data}, 32'h0B);

      fill(1, 8'h7F, 8'h00, 8'h7F);
      run_layer(5'd1, 1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      chk("sat_pos", {24'd0, last_data}, 32'h7F);

      fill(1, 8'h80, 8'h00, 8'h80);
      run_layer(5'd1, 1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      chk("sat_neg", {24'd0, last_data}, 32'h80);

      fill(1, 8'h00, 8'h00, 8'hFB);
      run_layer(5'd1, 1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      chk("relu_off", {24'd0, last_data}, 32'hD8);

      run_layer(5'd1, 1, 1'b1, 1'b1, -1, 1'b0, 1'b1);
      chk("relu_on", {24'd0, last_data}, 32'h00);

      fill(3, 8'h01, 8'h01, 8'h02);
      run_layer(5'd3, 3, 1'b0, 1'b1, 1, 1'b1, 1'b0);
      chk("multi_last", {24'd0, last_data}, 32'h13);

      start = 1'b1; num_neurons = 5'd0;
      tick;
      start = 1'b0;
      chk("zero_start_busy", {31'd0, busy}, 32'd0);
      chk("zero_start_in_ready", {31'd0, in_ready}, 32'd0);
      tick;
      chk("zero_start_done", {31'd0, done}, 32'd0);

      fill(16, 8'h00, 8'h01, 8'h00);
      run_layer(5'd20, 16, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      chk("clamp_last", {24'd0, last_data}, 32'h0F);

      write_bias(4'd0, 8'h10);
      start_layer(5'd2, 1'b0, 1'b0);
      for (int b = 0; b < 4; b++) send_beat(8'h05);
      rst = 1'b1;
      tick;
      exp_q.delete();
      rst = 1'b0;
      check_reset_outputs("midload_reset");
      tick;
      chk("no_done_after_reset", {31'd0, done}, 32'd0);

      fill(2, 8'h00, 8'h00, 8'h01);
      run_layer(5'd2, 2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      chk("post_reset_bias_zero", {24'd0, last_data}, 32'h08);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
